// File: rtl/div_ratio_detect_pkg.sv
// Shared divider definitions: default num_div width, detector state encoding and
// the half-period range helper.
package div_ratio_detect_pkg;

    // Width of the even divider's num_div field.
    localparam int unsigned DivWidthNumDiv = 4;

    typedef enum logic [1:0] {
        StSearch = 2'd0,
        StTrack  = 2'd1,
        StLocked = 2'd2
    } det_state_e;

    // Largest half period whose doubled ratio still fits in a num_div field of this width.
    function automatic int unsigned half_max(input int unsigned width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level plus a delay flop; flags either edge.
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic edge_o
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    // Synchronizer chain followed by the edge-detect delay stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign edge_o = sync_q ^ dly_q;

endmodule

// File: rtl/div_ratio_detect.sv
// Measures the half period of a divided clock sampled as data and reports the even
// division ratio once consecutive half periods agree.
module div_ratio_detect
    import div_ratio_detect_pkg::*;
#(
    parameter int unsigned WIDTH_NUM_DIV = DivWidthNumDiv,
    parameter int unsigned LOCK_CNT      = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clk_div_in,
    output logic [WIDTH_NUM_DIV-1:0] ratio_out,
    output logic                     ratio_valid,
    output logic                     lock,
    output logic                     err
);

    localparam int unsigned HalfMax = half_max(WIDTH_NUM_DIV);
    localparam logic [WIDTH_NUM_DIV-1:0] HalfMaxW = WIDTH_NUM_DIV'(HalfMax);
    // First count that can no longer be a legal half period.
    localparam logic [WIDTH_NUM_DIV-1:0] TimeoutW = WIDTH_NUM_DIV'(HalfMax + 1);
    localparam logic [2:0] LockCntW = 3'(LOCK_CNT);

    logic div_edge;

    det_state_e               state_q, state_d;
    logic [WIDTH_NUM_DIV-1:0] hcnt_q, hcnt_d;
    logic [WIDTH_NUM_DIV-1:0] prev_h_q, prev_h_d;
    logic                     prev_valid_q, prev_valid_d;
    logic [2:0]               match_cnt_q, match_cnt_d;
    logic [WIDTH_NUM_DIV-1:0] ratio_out_q, ratio_out_d;
    logic                     ratio_valid_q, ratio_valid_d;
    logic                     lock_q, lock_d;
    logic                     err_q, err_d;

    logic       timeout;
    logic       h_bad;
    logic [2:0] match_next;

    sync_edge_det u_sync_edge_det (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (clk_div_in),
        .edge_o (div_edge)
    );

    // Half-period counter: restarts at 1 on every edge so its value at the next edge is H.
    always_comb begin
        hcnt_d = div_edge ? WIDTH_NUM_DIV'(1) : hcnt_q + WIDTH_NUM_DIV'(1);
    end

    // Measurement FSM; timeout and range errors take priority over a coincident edge.
    always_comb begin
        state_d       = state_q;
        prev_h_d      = prev_h_q;
        prev_valid_d  = prev_valid_q;
        match_cnt_d   = match_cnt_q;
        ratio_out_d   = ratio_out_q;
        ratio_valid_d = 1'b0;
        lock_d        = lock_q;
        err_d         = 1'b0;
        match_next    = match_cnt_q + 3'd1;
        timeout       = (hcnt_q == TimeoutW);
        h_bad         = (hcnt_q == '0) || (hcnt_q > HalfMaxW);

        case (state_q)
            StSearch: begin
                lock_d = 1'b0;
                if (div_edge) begin
                    state_d      = StTrack;
                    prev_valid_d = 1'b0;
                    match_cnt_d  = 3'd0;
                end
            end
            StTrack, StLocked: begin
                if (timeout || (div_edge && h_bad)) begin
                    err_d        = 1'b1;
                    lock_d       = 1'b0;
                    state_d      = StSearch;
                    prev_valid_d = 1'b0;
                    match_cnt_d  = 3'd0;
                end else if (div_edge) begin
                    if (state_q == StTrack) begin
                        if (!prev_valid_q) begin
                            // First measured half after an acquisition: nothing to compare yet.
                            prev_h_d     = hcnt_q;
                            prev_valid_d = 1'b1;
                        end else if (hcnt_q == prev_h_q) begin
                            match_cnt_d = match_next;
                            if (match_next == LockCntW) begin
                                state_d       = StLocked;
                                ratio_out_d   = {hcnt_q[WIDTH_NUM_DIV-2:0], 1'b0};
                                ratio_valid_d = 1'b1;
                                lock_d        = 1'b1;
                            end
                        end else begin
                            match_cnt_d = 3'd0;
                            prev_h_d    = hcnt_q;
                        end
                    end else if (hcnt_q != prev_h_q) begin
                        // Ratio changed: drop lock but keep reporting the last good ratio.
                        state_d     = StTrack;
                        lock_d      = 1'b0;
                        prev_h_d    = hcnt_q;
                        match_cnt_d = 3'd0;
                    end
                end
            end
            default: begin
                state_d = StSearch;
                lock_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StSearch;
            hcnt_q        <= '0;
            prev_h_q      <= '0;
            prev_valid_q  <= 1'b0;
            match_cnt_q   <= 3'd0;
            ratio_out_q   <= '0;
            ratio_valid_q <= 1'b0;
            lock_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            prev_h_q      <= prev_h_d;
            prev_valid_q  <= prev_valid_d;
            match_cnt_q   <= match_cnt_d;
            ratio_out_q   <= ratio_out_d;
            ratio_valid_q <= ratio_valid_d;
            lock_q        <= lock_d;
            err_q         <= err_d;
        end
    end

    assign ratio_out   = ratio_out_q;
    assign ratio_valid = ratio_valid_q;
    assign lock        = lock_q;
    assign err         = err_q;

endmodule

// File: tb/tb_div_ratio_detect.sv
// Directed bench for div_ratio_detect: toggles clk_div_in at chosen half periods and
// checks lock, ratio, pulses and reset behaviour at hand-computed cycles.
module tb_div_ratio_detect;

    logic       clk;
    logic       rst_n;
    logic       clk_div_in;
    logic [3:0] ratio_out;
    logic       ratio_valid;
    logic       lock;
    logic       err;

    int tests;
    int fails;
    int vcnt;
    int ecnt;
    int both_cnt;
    int lock_hi_cnt;
    int v0;
    int e0;
    int l0;

    div_ratio_detect #(
        .WIDTH_NUM_DIV (4),
        .LOCK_CNT      (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_div_in  (clk_div_in),
        .ratio_out   (ratio_out),
        .ratio_valid (ratio_valid),
        .lock        (lock),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse/level counters sampled mid-cycle.
    always @(negedge clk) begin
        if (ratio_valid === 1'b1) vcnt++;
        if (err === 1'b1) ecnt++;
        if (ratio_valid === 1'b1 && err === 1'b1) both_cnt++;
        if (lock === 1'b1) lock_hi_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // n toggles, each followed by h clock cycles.
    task automatic tog(input int h, input int n);
        for (int i = 0; i < n; i++) begin
            clk_div_in = ~clk_div_in;
            repeat (h) step();
        end
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        vcnt        = 0;
        ecnt        = 0;
        both_cnt    = 0;
        lock_hi_cnt = 0;
        rst_n       = 1'b0;
        clk_div_in  = 1'b0;
        repeat (3) step();

        check("reset_ratio_out", 32'(ratio_out), 0);
        check("reset_lock", 32'(lock), 0);
        check("reset_ratio_valid", 32'(ratio_valid), 0);
        check("reset_err", 32'(err), 0);

        rst_n = 1'b1;
        repeat (2) step();

        // Half period 2 (num_div=4): lock visible three cycles after the 4th toggle.
        v0 = vcnt;
        tog(2, 4);
        check("div4_no_lock_yet", 32'(lock), 0);
        clk_div_in = ~clk_div_in;
        step();
        check("div4_lock_rise", 32'(lock), 1);
        check("div4_ratio", 32'(ratio_out), 4);
        check("div4_valid_pulse", 32'(ratio_valid), 1);
        step();
        check("div4_valid_one_cycle", 32'(ratio_valid), 0);
        tog(2, 10);
        check("div4_lock_hold", 32'(lock), 1);
        check("div4_valid_count", 32'(vcnt - v0), 1);

        // Switch to half period 4 (num_div=8): drop lock, relock at 8.
        v0 = vcnt;
        tog(4, 1);
        tog(4, 1);
        check("div8_lock_drop", 32'(lock), 0);
        check("div8_ratio_holds", 32'(ratio_out), 4);
        tog(4, 2);
        check("div8_relock", 32'(lock), 1);
        check("div8_ratio", 32'(ratio_out), 8);
        check("div8_valid_count", 32'(vcnt - v0), 1);

        // Stop toggling: timeout when hcnt reaches 8.
        e0 = ecnt;
        repeat (6) step();
        check("timeout_err_early", 32'(err), 0);
        check("timeout_lock_early", 32'(lock), 1);
        step();
        check("timeout_err_pulse", 32'(err), 1);
        check("timeout_lock_low", 32'(lock), 0);
        step();
        check("timeout_err_one_cycle", 32'(err), 0);
        repeat (20) step();
        check("timeout_err_count", 32'(ecnt - e0), 1);
        check("timeout_stay_unlocked", 32'(lock), 0);

        // num_div=2: toggle every cycle.
        e0 = ecnt;
        tog(1, 12);
        check("div2_lock", 32'(lock), 1);
        check("div2_ratio", 32'(ratio_out), 2);

        // num_div=14: half period 7, the longest legal one.
        v0 = vcnt;
        tog(7, 6);
        check("div14_lock", 32'(lock), 1);
        check("div14_ratio", 32'(ratio_out), 14);
        check("div14_valid_count", 32'(vcnt - v0), 1);
        check("div2_div14_no_err", 32'(ecnt - e0), 0);

        // Odd source 3 high / 4 low never locks and never errors.
        e0 = ecnt;
        v0 = vcnt;
        for (int i = 0; i < 2; i++) begin
            tog(3, 1);
            tog(4, 1);
        end
        l0 = lock_hi_cnt;
        for (int i = 0; i < 8; i++) begin
            tog(3, 1);
            tog(4, 1);
        end
        check("odd_lock_low", 32'(lock), 0);
        check("odd_lock_never_high", 32'(lock_hi_cnt - l0), 0);
        check("odd_no_err", 32'(ecnt - e0), 0);
        check("odd_no_valid", 32'(vcnt - v0), 0);
        check("odd_ratio_holds", 32'(ratio_out), 14);

        // Asynchronous reset mid-TRACK, then fresh acquisition at num_div=6.
        rst_n      = 1'b0;
        clk_div_in = 1'b0;
        #1;
        check("midreset_ratio_out", 32'(ratio_out), 0);
        check("midreset_lock", 32'(lock), 0);
        check("midreset_valid", 32'(ratio_valid), 0);
        check("midreset_err", 32'(err), 0);
        repeat (2) step();
        rst_n = 1'b1;
        v0    = vcnt;
        step();
        tog(3, 3);
        check("div6_no_lock_after_3", 32'(lock), 0);
        tog(3, 5);
        check("div6_lock", 32'(lock), 1);
        check("div6_ratio", 32'(ratio_out), 6);
        check("div6_valid_count", 32'(vcnt - v0), 1);

        check("valid_err_never_both", 32'(both_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_ratio_detect.md
DIV_RATIO_DETECT -- requirements
Module: div_ratio_detect

Interface
- REQ-001: Parameter WIDTH_NUM_DIV, default 4; width of the division-ratio field, matching the even divider's num_div width.
- REQ-002: Parameter LOCK_CNT, default 2; number of consecutive matching half-period comparisons required for lock (range 1..7).
- REQ-003: clk  input  1  system clock; the block has one clock only.
- REQ-004: rst_n  input  1  reset, asynchronous assert, active-low.
- REQ-005: clk_div_in  input  1  divided clock under test; treated as asynchronous data, never used as a clock.
- REQ-006: ratio_out  output  WIDTH_NUM_DIV  detected even division ratio (2 x half-period length, in clk cycles).
- REQ-007: ratio_valid  output  1  one-cycle pulse when ratio_out is loaded with a new value.
- REQ-008: lock  output  1  high while the measured ratio is stable.
- REQ-009: err  output  1  one-cycle pulse on a timeout or a half-period out of range.

Function
- REQ-010: clk_div_in SHALL pass through a 2-flop synchronizer; a third flop SHALL provide edge detection; edge = synced XOR delayed (either polarity).
- REQ-011: Half counter hcnt SHALL be WIDTH_NUM_DIV bits wide, SHALL load 1 on an edge cycle, and SHALL increment on non-edge cycles.
- REQ-012: On an edge, the measured half length H SHALL equal the hcnt value in that cycle, so a source toggling every H clk cycles yields H.
- REQ-013: Valid range is 1 <= H <= 2^(WIDTH_NUM_DIV-1)-1; ratio = 2*H fits in WIDTH_NUM_DIV bits.
- REQ-014: States SHALL be SEARCH, TRACK, LOCKED; reset state SEARCH.
- REQ-015: SEARCH: wait for an edge; on edge -> TRACK, hcnt=1, prev_h invalid, match_cnt=0.
- REQ-016: TRACK, first edge after SEARCH: store prev_h=H without comparing.
- REQ-017: TRACK, later edges: H==prev_h -> match_cnt+1; otherwise match_cnt=0 and prev_h=H.
- REQ-018: TRACK: when match_cnt reaches LOCK_CNT -> LOCKED; in the same transition ratio_out=2*H, lock=1 and ratio_valid pulses in the following cycle.
- REQ-019: LOCKED, H==prev_h: hold; no ratio_valid pulse.
- REQ-020: LOCKED, H!=prev_h: lock=0 next cycle, -> TRACK, prev_h=H, match_cnt=0; ratio_out holds its last value.
- REQ-021: Timeout, in TRACK or LOCKED: hcnt reaching 2^(WIDTH_NUM_DIV-1) without an edge -> err pulse, lock=0, -> SEARCH.
- REQ-022: A static input (stopped divider) SHALL therefore always end in SEARCH with lock=0.
- REQ-023: An edge in the same cycle as the timeout threshold SHALL be treated as the timeout (err wins).
- REQ-024: ratio_valid and err SHALL never be high in the same cycle.
- REQ-025: Asymmetric halves (odd source ratio) SHALL never lock, because successive H values differ.

Reset
- REQ-026: rst_n low SHALL asynchronously clear all synchronizer and edge flops to 0, hcnt=0, prev_h=0, match_cnt=0, state=SEARCH, ratio_out=0, ratio_valid=0, lock=0, err=0.
- REQ-027: Reset asserted mid-measurement SHALL discard all history; after release, a fresh first edge is required before any measurement.

Structure
- REQ-028: State encoding and the derived constant HALF_MAX=2^(WIDTH_NUM_DIV-1)-1 SHALL live in the shared divider package, alongside the divider's constants.
- REQ-029: The synchronizer plus edge detector SHALL be a sub-module named sync_edge_det, reusable by other clock-domain inputs.

Verification
- REQ-030: Drive from divider_even with num_div=4, LOCK_CNT=2 -> edges every 2 cycles; lock rises after the 4th synced edge; ratio_out=4; one ratio_valid pulse.
- REQ-031: num_div=2 (toggle every cycle) -> ratio_out=2, lock=1; num_div=14 -> ratio_out=14, lock=1.
- REQ-032: While locked at 4, switch the source to num_div=8 -> lock drops; relock with ratio_out=8; exactly one new ratio_valid pulse.
- REQ-033: Hold clk_div_in constant for 8 cycles while locked -> err pulses once at hcnt=8, lock=0, state SEARCH.
- REQ-034: Odd source (3 high / 4 low) -> lock stays 0 indefinitely; no err.
- REQ-035: Assert rst_n mid-TRACK -> all outputs 0 immediately; after release with num_div=6 -> ratio_out=6 after relock.
